// File: rtl/fnd_scan_ctrl_watch.sv
// fnd_scan_ctrl_watch
// Scan controller for a 4-digit common-anode FND watch display. Each accepted
// 1 kHz tick blanks all commons for BLANK_CYCLES clocks, then drives the next
// digit with its BCD value and decimal point. Watch values and the page are
// snapshotted at frame start so a frame never mixes two readings. Page toggles
// requested by the button are held pending and applied only at frame boundaries.
module fnd_scan_ctrl_watch #(
  parameter int BLANK_CYCLES = 1,
  parameter bit DP_BLINK_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick_1khz,
  input  logic       i_page_btn,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  output logic       o_sel,
  output logic [3:0] o_fnd_com,
  output logic [3:0] o_bcd,
  output logic       o_dp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] scan_idx;
  logic       pending;
  logic [3:0] blank_cnt;

  logic [6:0] snap_msec;
  logic [5:0] snap_sec;
  logic [5:0] snap_min;
  logic [4:0] snap_hour;
  logic       snap_page;

  logic       eff_pending;
  logic       next_page;
  logic [7:0] hi_bcd;
  logic [7:0] lo_bcd;
  logic [3:0] digit;
  logic       dp_on;

  // Clamp a displayed value to two decimal digits.
  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  // Split 0..99 into {tens, ones} with weighted compare/subtract steps.
  function automatic logic [7:0] split_bcd(input logic [6:0] v);
    logic [6:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    if (r >= 7'd80) begin
      r = r - 7'd80;
      t = t + 4'd8;
    end
    if (r >= 7'd40) begin
      r = r - 7'd40;
      t = t + 4'd4;
    end
    if (r >= 7'd20) begin
      r = r - 7'd20;
      t = t + 4'd2;
    end
    if (r >= 7'd10) begin
      r = r - 7'd10;
      t = t + 4'd1;
    end
    return {t, 4'(r)};
  endfunction

  // A press landing on the boundary clock counts toward that boundary.
  assign eff_pending = pending ^ i_page_btn;
  assign next_page   = o_sel ^ eff_pending;

  // Digit and decimal point for the current scan index from the frame snapshot.
  always_comb begin
    hi_bcd = 8'd0;
    lo_bcd = 8'd0;
    digit  = 4'd0;
    if (snap_page) begin
      hi_bcd = split_bcd(sat99({2'b00, snap_hour}));
      lo_bcd = split_bcd(sat99({1'b0, snap_min}));
    end else begin
      hi_bcd = split_bcd(sat99({1'b0, snap_sec}));
      lo_bcd = split_bcd(sat99(snap_msec));
    end
    case (scan_idx)
      2'd0:    digit = lo_bcd[3:0];
      2'd1:    digit = lo_bcd[7:4];
      2'd2:    digit = hi_bcd[3:0];
      default: digit = hi_bcd[7:4];
    endcase
    dp_on = DP_BLINK_EN && (scan_idx == 2'd2) &&
            (snap_page ? ~snap_sec[0] : (snap_msec < 7'd50));
  end

  // Scan FSM: tick -> blank all commons -> drive one digit, plus page/snapshot control.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      scan_idx  <= 2'd0;
      pending   <= 1'b0;
      blank_cnt <= 4'd0;
      o_sel     <= 1'b0;
      o_fnd_com <= 4'b1111;
      o_bcd     <= 4'd0;
      o_dp      <= 1'b1;
      snap_msec <= 7'd0;
      snap_sec  <= 6'd0;
      snap_min  <= 6'd0;
      snap_hour <= 5'd0;
      snap_page <= 1'b0;
    end else begin
      pending <= eff_pending;
      case (state)
        IDLE: begin
          if (i_tick_1khz) begin
            // First tick after reset starts a frame at digit 0 without a page change.
            state     <= BLANK;
            blank_cnt <= 4'd0;
            scan_idx  <= 2'd0;
            o_fnd_com <= 4'b1111;
            o_dp      <= 1'b1;
            snap_msec <= i_msec;
            snap_sec  <= i_sec;
            snap_min  <= i_min;
            snap_hour <= i_hour;
            snap_page <= o_sel;
          end
        end
        BLANK: begin
          // Ticks arriving here are dropped on purpose.
          if (blank_cnt == 4'(BLANK_CYCLES - 1)) begin
            state     <= DRIVE;
            blank_cnt <= 4'd0;
            o_fnd_com <= ~(4'b0001 << scan_idx);
            o_bcd     <= digit;
            o_dp      <= ~dp_on;
          end else begin
            blank_cnt <= blank_cnt + 4'd1;
          end
        end
        DRIVE: begin
          if (i_tick_1khz) begin
            state     <= BLANK;
            blank_cnt <= 4'd0;
            scan_idx  <= scan_idx + 2'd1;
            o_fnd_com <= 4'b1111;
            o_dp      <= 1'b1;
            if (scan_idx == 2'd3) begin
              o_sel     <= next_page;
              pending   <= 1'b0;
              snap_msec <= i_msec;
              snap_sec  <= i_sec;
              snap_min  <= i_min;
              snap_hour <= i_hour;
              snap_page <= next_page;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl_watch.sv
// Bench for fnd_scan_ctrl_watch: directed scenarios followed by random traffic,
// every clock compared against a behavioural model of the scan display.
module tb_fnd_scan_ctrl_watch;

  localparam int BLANK_CYCLES = 1;
  localparam bit DP_BLINK_EN  = 1'b1;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       btn;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       sel;
  logic [3:0] fnd_com;
  logic [3:0] bcd;
  logic       dp;

  int checks = 0;
  int errors = 0;

  fnd_scan_ctrl_watch #(
    .BLANK_CYCLES(BLANK_CYCLES),
    .DP_BLINK_EN (DP_BLINK_EN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_tick_1khz(tick),
    .i_page_btn (btn),
    .i_msec     (msec),
    .i_sec      (sec),
    .i_min      (min),
    .i_hour     (hour),
    .o_sel      (sel),
    .o_fnd_com  (fnd_com),
    .o_bcd      (bcd),
    .o_dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 waiting for first tick, 1 commons dark, 2 showing a digit
  int       m_mode;
  int       m_left;
  int       m_idx;
  bit       m_sel;
  bit       m_pend;
  bit       m_page;
  int       m_msec, m_sec, m_min, m_hour;
  bit [3:0] e_com;
  bit [3:0] e_bcd;
  bit       e_dp;
  bit [3:0] com_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic int clamp99(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  function automatic int model_digit(input int idx);
    int hi, lo;
    hi = clamp99(m_page ? m_hour : m_sec);
    lo = clamp99(m_page ? m_min : m_msec);
    case (idx)
      0:       return lo % 10;
      1:       return lo / 10;
      2:       return hi % 10;
      default: return hi / 10;
    endcase
  endfunction

  function automatic bit model_dp_low(input int idx);
    if (!DP_BLINK_EN || idx != 2) return 1'b0;
    return m_page ? ((m_sec % 2) == 0) : (m_msec < 50);
  endfunction

  task automatic take_snapshot();
    m_msec = msec;
    m_sec  = sec;
    m_min  = min;
    m_hour = hour;
    m_page = m_sel;
  endtask

  task automatic model_clk(input bit r, input bit t, input bit b);
    bit next_pend;
    if (r) begin
      m_mode = 0; m_left = 0; m_idx = 0; m_sel = 0; m_pend = 0;
      m_page = 0; m_msec = 0; m_sec = 0; m_min = 0; m_hour = 0;
      e_com = 4'b1111; e_bcd = 4'd0; e_dp = 1'b1;
      return;
    end
    next_pend = m_pend ^ b;
    if (m_mode == 0 && t) begin
      m_idx = 0;
      take_snapshot();
      m_mode = 1; m_left = BLANK_CYCLES;
      e_com = 4'b1111; e_dp = 1'b1;
    end else if (m_mode == 2 && t) begin
      if (m_idx == 3) begin
        m_sel = m_sel ^ next_pend;
        next_pend = 1'b0;
        m_idx = 0;
        take_snapshot();
      end else begin
        m_idx = m_idx + 1;
      end
      m_mode = 1; m_left = BLANK_CYCLES;
      e_com = 4'b1111; e_dp = 1'b1;
    end else if (m_mode == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_mode = 2;
        e_com = com_tab[m_idx];
        e_bcd = 4'(model_digit(m_idx));
        e_dp  = !model_dp_low(m_idx);
      end
    end
    m_pend = next_pend;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("model_com", {4'd0, fnd_com}, {4'd0, e_com});
    chk("model_bcd", {4'd0, bcd}, {4'd0, e_bcd});
    chk("model_dp", {7'd0, dp}, {7'd0, e_dp});
    chk("model_sel", {7'd0, sel}, {7'd0, m_sel});
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input bit r, input bit t, input bit b);
    rst = r; tick = t; btn = b;
    @(posedge clk);
    model_clk(r, t, b);
    #1;
    check_model();
  endtask

  // Accepted tick followed by the blanking gap; ends on the drive edge.
  task automatic do_tick(input bit b);
    step(1'b0, 1'b1, b);
    chk("tick_blank", {4'd0, fnd_com}, 8'h0F);
    repeat (BLANK_CYCLES) step(1'b0, 1'b0, 1'b0);
  endtask

  // Advance until digit 3 is showing, then take the boundary tick.
  task automatic goto_frame_start(input bit b);
    int guard;
    guard = 0;
    while (!(m_mode == 2 && m_idx == 3) && guard < 8) begin
      do_tick(1'b0);
      guard++;
    end
    chk("frame_reach", {7'd0, (m_mode == 2 && m_idx == 3)}, 8'd1);
    do_tick(b);
  endtask

  task automatic expect_digit(input string tag, input logic [3:0] c,
                              input logic [3:0] d, input logic p);
    chk({tag, "_com"}, {4'd0, fnd_com}, {4'd0, c});
    chk({tag, "_bcd"}, {4'd0, bcd}, {4'd0, d});
    chk({tag, "_dp"}, {7'd0, dp}, {7'd0, p});
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; btn = 1'b0;
    msec = 7'd0; sec = 6'd0; min = 6'd0; hour = 5'd0;

    // Reset, then idle with no ticks: everything dark and stable.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    chk("idle_com", {4'd0, fnd_com}, 8'h0F);
    chk("idle_bcd", {4'd0, bcd}, 8'h00);
    chk("idle_dp", {7'd0, dp}, 8'd1);
    chk("idle_sel", {7'd0, sel}, 8'd0);

    // sec=42 msec=07: four digits, each after its blanking gap.
    sec = 6'd42; msec = 7'd7; min = 6'd5; hour = 5'd23;
    do_tick(1'b0); expect_digit("s42_d0", 4'b1110, 4'd7, 1'b1);
    do_tick(1'b0); expect_digit("s42_d1", 4'b1101, 4'd0, 1'b1);
    do_tick(1'b0); expect_digit("s42_d2", 4'b1011, 4'd2, 1'b0);
    do_tick(1'b0); expect_digit("s42_d3", 4'b0111, 4'd4, 1'b1);

    // One press mid-frame: page holds until the 3->0 boundary.
    do_tick(1'b0);
    step(1'b0, 1'b0, 1'b1);
    do_tick(1'b0); do_tick(1'b0); do_tick(1'b0);
    chk("pend_hold_sel", {7'd0, sel}, 8'd0);
    do_tick(1'b0);
    chk("pend_apply_sel", {7'd0, sel}, 8'd1);
    expect_digit("hm_d0", 4'b1110, 4'd5, 1'b1);
    do_tick(1'b0); expect_digit("hm_d1", 4'b1101, 4'd0, 1'b1);
    do_tick(1'b0); expect_digit("hm_d2", 4'b1011, 4'd3, 1'b0);
    do_tick(1'b0); expect_digit("hm_d3", 4'b0111, 4'd2, 1'b1);

    // Two presses in one frame cancel.
    do_tick(1'b0);
    step(1'b0, 1'b0, 1'b1);
    do_tick(1'b0);
    step(1'b0, 1'b0, 1'b1);
    do_tick(1'b0); do_tick(1'b0); do_tick(1'b0);
    chk("cancel_sel", {7'd0, sel}, 8'd1);

    // Press on the boundary clock is taken at that boundary.
    goto_frame_start(1'b1);
    chk("btn_on_boundary_sel", {7'd0, sel}, 8'd0);

    // Saturation: msec=120 sec=59 -> 9,9,9,5 and DP off on idx2.
    msec = 7'd120; sec = 6'd59;
    goto_frame_start(1'b0);
    expect_digit("sat_d0", 4'b1110, 4'd9, 1'b1);
    do_tick(1'b0); expect_digit("sat_d1", 4'b1101, 4'd9, 1'b1);
    do_tick(1'b0); expect_digit("sat_d2", 4'b1011, 4'd9, 1'b1);
    do_tick(1'b0); expect_digit("sat_d3", 4'b0111, 4'd5, 1'b1);

    // msec=30: DP low on idx2 only.
    msec = 7'd30;
    goto_frame_start(1'b0);
    expect_digit("dp_d0", 4'b1110, 4'd0, 1'b1);
    do_tick(1'b0); expect_digit("dp_d1", 4'b1101, 4'd3, 1'b1);
    do_tick(1'b0); expect_digit("dp_d2", 4'b1011, 4'd9, 1'b0);
    do_tick(1'b0); expect_digit("dp_d3", 4'b0111, 4'd5, 1'b1);

    // Reset mid-frame while idx2 is driven on page 1.
    step(1'b0, 1'b0, 1'b1);
    goto_frame_start(1'b0);
    chk("pre_rst_sel", {7'd0, sel}, 8'd1);
    do_tick(1'b0); do_tick(1'b0);
    chk("pre_rst_com", {4'd0, fnd_com}, 8'h0B);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_mid_com", {4'd0, fnd_com}, 8'h0F);
    chk("rst_mid_sel", {7'd0, sel}, 8'd0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    do_tick(1'b0);
    chk("post_rst_com", {4'd0, fnd_com}, 8'h0E);

    // Random traffic: dense ticks (some land in blanking), presses, resets.
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        msec = 7'($urandom_range(0, 127));
        sec  = 6'($urandom_range(0, 63));
        min  = 6'($urandom_range(0, 63));
        hour = 5'($urandom_range(0, 31));
      end
      step($urandom_range(0, 799) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
